// File: rtl/pad_pkg.sv
// Shared types and default sizing for the pad sequencer and its round-robin arbiter.
// The arbitration pick function lives here so the arbiter and any checker agree on it.
package pad_pkg;

  localparam int DEF_KEY_W          = 32;
  localparam int DEF_STEPS_PER_WORD = 8;
  localparam int DEF_MAX_WORDS      = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ADVANCE   = 3'd2,
    ST_READY     = 3'd3,
    ST_EXHAUSTED = 3'd4
  } state_t;

  // prio = 1 favours req[1] when both requesters are active
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = prio ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/pad_rr_arb.sv
// Two-way round-robin arbiter; the priority pointer only moves when a grant is consumed.
// After reset the pointer favours requester 0.
module pad_rr_arb
  import pad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_r;

  // Combinational pick from current requests and priority pointer
  always_comb begin
    grant = rr_pick(req, prio_r);
  end

  // Pointer moves to favour the requester that did not just win
  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_r <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      prio_r <= grant[0];
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/pad_sequencer.sv
// Sequences an external keystream generator and hands each pad word to one of two
// requesters, locking out further grants once MAX_WORDS words have been issued.
module pad_sequencer
  import pad_pkg::*;
#(
  parameter int KEY_W          = DEF_KEY_W,
  parameter int STEPS_PER_WORD = DEF_STEPS_PER_WORD,
  parameter int MAX_WORDS      = DEF_MAX_WORDS,
  parameter int IDX_W          = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] cfg_seed,
  input  logic             cfg_start,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic [KEY_W-1:0] pad_word,
  output logic [IDX_W-1:0] pad_idx,
  output logic             busy,
  output logic             exhausted,
  output logic [KEY_W-1:0] kg_seed,
  output logic             kg_load,
  output logic             kg_adv,
  input  logic [KEY_W-1:0] kg_key
);

  localparam int                 STEP_CW   = $clog2(STEPS_PER_WORD + 1);
  localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEPS_PER_WORD - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(MAX_WORDS - 1);

  state_t             state_r;
  state_t             state_nx_s;
  logic [STEP_CW-1:0] step_r;
  logic [STEP_CW-1:0] step_nx_s;
  logic [IDX_W-1:0]   word_r;
  logic [IDX_W-1:0]   word_nx_s;
  logic [KEY_W-1:0]   seed_r;
  logic               take_s;
  logic [1:0]         arb_gnt_s;

  pad_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (take_s),
    .grant  (arb_gnt_s)
  );

  // Next-state, step counter and word counter; cfg_start overrides every state
  always_comb begin
    state_nx_s = state_r;
    step_nx_s  = step_r;
    word_nx_s  = word_r;
    take_s     = 1'b0;
    if (cfg_start) begin
      state_nx_s = ST_LOAD;
      step_nx_s  = '0;
      word_nx_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_LOAD: begin
          state_nx_s = ST_ADVANCE;
          step_nx_s  = '0;
          word_nx_s  = '0;
        end
        ST_ADVANCE: begin
          if (step_r == STEP_LAST) begin
            state_nx_s = ST_READY;
            step_nx_s  = '0;
          end else begin
            step_nx_s  = step_r + STEP_CW'(1);
          end
        end
        ST_READY: begin
          if (arb_gnt_s != 2'b00) begin
            take_s     = 1'b1;
            word_nx_s  = word_r + IDX_W'(1);
            state_nx_s = (word_r == IDX_LAST) ? ST_EXHAUSTED : ST_ADVANCE;
          end else begin
            state_nx_s = ST_READY;
          end
        end
        ST_EXHAUSTED: begin
          state_nx_s = ST_EXHAUSTED;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, latched seed and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      step_r    <= '0;
      word_r    <= '0;
      seed_r    <= '0;
      gnt       <= 2'b00;
      pad_word  <= '0;
      pad_idx   <= '0;
      busy      <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      step_r    <= step_nx_s;
      word_r    <= word_nx_s;
      busy      <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_ADVANCE);
      exhausted <= (state_nx_s == ST_EXHAUSTED);
      gnt       <= take_s ? arb_gnt_s : 2'b00;
      if (cfg_start) begin
        seed_r  <= cfg_seed;
        pad_idx <= '0;
      end else if (take_s) begin
        pad_word <= kg_key;
        pad_idx  <= word_r;
      end else begin
        seed_r   <= seed_r;
        pad_word <= pad_word;
        pad_idx  <= pad_idx;
      end
    end
  end

  // Generator controls decode straight from state so key_gen reacts the same cycle
  always_comb begin
    kg_load = (state_r == ST_LOAD);
    kg_adv  = (state_r == ST_ADVANCE);
    kg_seed = seed_r;
  end

endmodule

// File: tb/tb_pad_sequencer.sv
// Scoreboard bench for pad_sequencer with a behavioural xorshift32 key_gen beside it.
// Stimulus pushes expected grants; a negedge monitor pops and compares each grant.
module tb_pad_sequencer;

  localparam int KW = 32;
  localparam int S  = 8;
  localparam int MW = 4;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  logic [KW-1:0] cfg_seed;
  logic          cfg_start;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [KW-1:0] pad_word;
  logic [IW-1:0] pad_idx;
  logic          busy;
  logic          exhausted;
  logic [KW-1:0] kg_seed;
  logic          kg_load;
  logic          kg_adv;
  logic [KW-1:0] kg_key;

  typedef struct packed {
    logic [1:0]    g;
    logic [IW-1:0] idx;
    logic [KW-1:0] w;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pad_sequencer #(
    .KEY_W(KW), .STEPS_PER_WORD(S), .MAX_WORDS(MW), .IDX_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_seed(cfg_seed), .cfg_start(cfg_start),
    .req(req), .gnt(gnt), .pad_word(pad_word), .pad_idx(pad_idx),
    .busy(busy), .exhausted(exhausted), .kg_seed(kg_seed),
    .kg_load(kg_load), .kg_adv(kg_adv), .kg_key(kg_key)
  );

  function automatic logic [KW-1:0] kg_step(input logic [KW-1:0] x);
    logic [KW-1:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [KW-1:0] kg_after(input logic [KW-1:0] seed, input int n);
    logic [KW-1:0] y;
    y = seed;
    for (int i = 0; i < n; i++) y = kg_step(y);
    return y;
  endfunction

  // Reference key_gen: load on kg_load, step on kg_adv
  always_ff @(posedge clk) begin
    if (!reset) kg_key <= '0;
    else if (kg_load) kg_key <= kg_seed;
    else if (kg_adv) kg_key <= kg_step(kg_key);
    else kg_key <= kg_key;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every grant must match the oldest expected entry
  always @(negedge clk) begin
    if (gnt !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_gnt: actual gnt=%b idx=%0d word=%h, required no grant", gnt, pad_idx, pad_word);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("grant", 64'({gnt, pad_idx, pad_word}), 64'({e.g, e.idx, e.w}));
      end
    end
  end

  task automatic load_and_check(input logic [KW-1:0] seed, input logic [1:0] r);
    cfg_seed  = seed;
    cfg_start = 1'b1;
    req       = r;
    tick();
    cfg_start = 1'b0;
    req       = 2'b00;
    check("load_kg_load", 64'(kg_load), 64'(1'b1));
    check("load_kg_seed", 64'(kg_seed), 64'(seed));
    check("load_gnt", 64'(gnt), 64'(2'b00));
    check("load_busy_exh_idx", 64'({busy, exhausted, pad_idx}), 64'({1'b1, 1'b0, 2'b00}));
    for (int i = 0; i < S; i++) begin
      tick();
      check("adv_kg", 64'({kg_load, kg_adv, busy}), 64'(3'b011));
    end
    tick();
    check("ready_reached", 64'({kg_load, kg_adv, busy}), 64'(3'b000));
  endtask

  task automatic request(input logic [1:0] r, input logic [1:0] g, input logic [IW-1:0] idx,
                         input logic [KW-1:0] w);
    logic got;
    exp_q.push_back('{g: g, idx: idx, w: w});
    req = r;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (gnt != 2'b00) got = 1'b1;
    end
    req = 2'b00;
    check("gnt_seen", 64'(got), 64'(1'b1));
    check("gnt_cycle_is_advance", 64'(kg_adv), 64'(1'b1));
  endtask

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
    check("wait_ready", 64'(ok), 64'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [KW-1:0] seed1, seed2, seed3, seed4, seed5;
    seed1 = 32'h0F53CC92;
    seed2 = 32'h12345678;
    seed3 = 32'hDEADBEEF;
    seed4 = 32'hA5A5_0001;
    seed5 = 32'h0000_BEEF;
    reset = 1'b0; cfg_start = 1'b0; cfg_seed = '0; req = 2'b00;
    tick(); tick();
    check("reset_outputs", 64'({gnt, pad_idx, busy, exhausted, kg_load, kg_adv}), 64'(0));
    check("reset_words", 64'({pad_word, kg_seed}), 64'(0));
    reset = 1'b1;
    // IDLE ignores requests
    req = 2'b11;
    repeat (5) tick();
    req = 2'b00;
    check("idle_quiet", 64'({busy, kg_load, kg_adv}), 64'(3'b000));

    // First load: timing and first word after 8 steps
    load_and_check(seed1, 2'b00);
    request(2'b01, 2'b01, 2'd0, kg_after(seed1, S));
    wait_ready();

    // Both requesting: alternation until exhaustion at MAX_WORDS=4
    exp_q.push_back('{g: 2'b10, idx: 2'd1, w: kg_after(seed1, 2 * S)});
    exp_q.push_back('{g: 2'b01, idx: 2'd2, w: kg_after(seed1, 3 * S)});
    exp_q.push_back('{g: 2'b10, idx: 2'd3, w: kg_after(seed1, 4 * S)});
    req = 2'b11;
    repeat (40) tick();
    req = 2'b00;
    check("exhausted_set", 64'({exhausted, busy, kg_adv}), 64'(3'b100));
    check("exhausted_hold", 64'({pad_idx, pad_word}), 64'({2'd3, kg_after(seed1, 4 * S)}));
    check("all_grants_seen", 64'(exp_q.size()), 64'(0));

    // Reload after exhaustion restarts at index 0
    load_and_check(seed2, 2'b00);
    request(2'b10, 2'b10, 2'd0, kg_after(seed2, S));
    wait_ready();

    // cfg_start in the middle of ADVANCE
    cfg_seed = seed3; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    repeat (4) tick();
    load_and_check(seed4, 2'b00);
    request(2'b01, 2'b01, 2'd0, kg_after(seed4, S));
    wait_ready();

    // cfg_start and req on the same READY edge: reload wins, pointer unchanged
    load_and_check(seed5, 2'b11);
    request(2'b11, 2'b10, 2'd0, kg_after(seed5, S));

    // Request dropped before READY consumes nothing
    req = 2'b01;
    repeat (3) tick();
    req = 2'b00;
    wait_ready();
    repeat (3) tick();
    request(2'b01, 2'b01, 2'd1, kg_after(seed5, 2 * S));
    wait_ready();

    // Reset in READY with requests pending
    req = 2'b11;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_ready_outputs", 64'({gnt, pad_idx, busy, exhausted, kg_load, kg_adv}), 64'(0));
    check("rst_ready_words", 64'({pad_word, kg_seed}), 64'(0));
    repeat (12) tick();
    req = 2'b00;
    check("rst_idle_quiet", 64'({busy, kg_load, kg_adv, exhausted}), 64'(4'b0000));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
